// File: rtl/mult_accum_pkg.sv
// Shared constants and the saturating/wrapping adder used by every accumulator lane.
package mult_accum_pkg;

    localparam int DEF_A_W   = 8;
    localparam int DEF_B_W   = 8;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_NCH   = 4;

    // Operates on the low w bits (w <= 63); returns {overflow, sum}.
    function automatic logic [64:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          w,
        input bit          sgn,
        input bit          sat
    );
        logic [63:0] mask, sum, hi, lo;
        logic [64:0] full;
        logic        c, sa, sb, sr, ov;
        mask = (64'd1 << w) - 64'd1;
        full = {1'b0, a & mask} + {1'b0, b & mask};
        sum  = full[63:0] & mask;
        c    = full[w];
        sa   = a[w-1];
        sb   = b[w-1];
        sr   = sum[w-1];
        ov   = sgn ? ((sa == sb) && (sr != sa)) : c;
        hi   = sgn ? (mask >> 1) : mask;
        lo   = 64'd1 << (w - 1);
        if (ov && sat)
            sum = (sgn && sa) ? lo : hi;
        return {ov, sum};
    endfunction

endpackage

// File: rtl/mult_accum_if.sv
// Operand, readback and result bundle of the multi-channel MAC.
interface mult_accum_if #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 32,
    parameter int NCH   = 4
);
    localparam int CH_W = $clog2(NCH);

    logic             clr;
    logic             en;
    logic [CH_W-1:0]  ch;
    logic [A_W-1:0]   A;
    logic [B_W-1:0]   B;
    logic [CH_W-1:0]  rd_ch;
    logic [ACC_W-1:0] rd_accum;
    logic             out_vld;
    logic [CH_W-1:0]  out_ch;
    logic [ACC_W-1:0] out_accum;
    logic [NCH-1:0]   ovf;

    modport master (
        output clr, en, ch, A, B, rd_ch,
        input  rd_accum, out_vld, out_ch, out_accum, ovf
    );

    modport slave (
        input  clr, en, ch, A, B, rd_ch,
        output rd_accum, out_vld, out_ch, out_accum, ovf
    );

endinterface

// File: rtl/mult_accum_mc_lane.sv
// One accumulator channel with sticky overflow flag; nxt is the value it would write.
module mac_acc_lane
    import mult_accum_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter bit SIGNED = 1'b0,
    parameter bit SAT    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] nxt,
    output logic             ovf
);

    logic [64:0] r;
    logic        ov;
    logic        unused_hi;

    always_comb begin
        r   = sat_add(64'(acc), 64'(addend), ACC_W, SIGNED, SAT);
        nxt = r[ACC_W-1:0];
        ov  = r[64];
    end

    assign unused_hi = ^r[63:ACC_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (we) begin
            acc <= nxt;
            if (ov)
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/mult_accum_mc.sv
// Two-stage multi-channel multiply-accumulate: registered product, then per-channel add.
module mult_accum_mc
    import mult_accum_pkg::*;
#(
    parameter int A_W    = DEF_A_W,
    parameter int B_W    = DEF_B_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int NCH    = DEF_NCH,
    parameter bit SIGNED = 1'b0,
    parameter bit SAT    = 1'b0
) (
    input logic       clk,
    input logic       rst,
    mult_accum_if.slave bus
);

    localparam int CH_W = $clog2(NCH);
    localparam int PW   = A_W + B_W;

    logic [PW-1:0]    prod, prod_reg;
    logic [CH_W-1:0]  ch_s1;
    logic             vld_s1;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] acc [NCH];
    logic [ACC_W-1:0] nxt [NCH];
    logic [NCH-1:0]   ovf_w;

    generate
        if (SIGNED) begin : g_sgn
            logic signed [PW-1:0] sa, sb;
            assign sa     = PW'($signed(bus.A));
            assign sb     = PW'($signed(bus.B));
            assign prod   = sa * sb;
            assign addend = ACC_W'($signed(prod_reg));
        end else begin : g_uns
            assign prod   = PW'(bus.A) * PW'(bus.B);
            assign addend = ACC_W'(prod_reg);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_reg <= '0;
            ch_s1    <= '0;
            vld_s1   <= 1'b0;
        end else begin
            vld_s1 <= bus.en;
            if (bus.en) begin
                prod_reg <= prod;
                ch_s1    <= bus.ch;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        mac_acc_lane #(
            .ACC_W (ACC_W),
            .SIGNED(SIGNED),
            .SAT   (SAT)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (bus.clr),
            .we    (vld_s1 && (ch_s1 == CH_W'(g))),
            .addend(addend),
            .acc   (acc[g]),
            .nxt   (nxt[g]),
            .ovf   (ovf_w[g])
        );
    end

    // A clear discards the stage-2 update landing on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_vld   <= 1'b0;
            bus.out_ch    <= '0;
            bus.out_accum <= '0;
        end else begin
            bus.out_vld <= vld_s1 && !bus.clr;
            if (vld_s1 && !bus.clr) begin
                bus.out_ch    <= ch_s1;
                bus.out_accum <= nxt[ch_s1];
            end
        end
    end

    assign bus.rd_accum = acc[bus.rd_ch];
    assign bus.ovf      = ovf_w;

endmodule
